dmem_responder: RTL and testbench



---
 rtl/dmem_responder.sv | 128 ++++++++++++
 tb/tb_dmem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - byte-lane data memory with timed, handshaked read responses
// Optional DMEM_WR_ACK_EN: every accepted write also returns a zero-data response.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        gwe,
  input  logic        rd,
  input  logic        bw0,
  input  logic        bw1,
  input  logic        bw2,
  input  logic        bw3,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] data_out,
  output logic        resp_err,
  output logic        err_sticky
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q;
  logic [1:0]    cnt_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic          err_sticky_q;
  logic [31:0]   data_out_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          accept;
  logic          wr;
  logic          in_range;
  logic          mem_we;
  logic [31:0]   offset;
  logic [AW-1:0] index;
  logic [3:0]    lane_en;

  assign accept   = req_valid & req_ready_q & (state_q == IDLE);
  assign wr       = gwe | bw0 | bw1 | bw2 | bw3;
  assign lane_en  = {4{gwe}} | {bw3, bw2, bw1, bw0};
  assign offset   = addr - BASE_ADDR;
  assign in_range = (addr >= BASE_ADDR) && ((offset >> 2) < DEPTH_WORDS);
  assign index    = offset[AW+1:2];
  // A read that also asserts a write lane is illegal and must not touch memory.
  assign mem_we   = ~rst & accept & wr & ~rd & in_range;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[index][8*i +: 8] <= data_in[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      data_out_q   <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (wr && !rd) begin
              if (!in_range) err_sticky_q <= 1'b1;
`ifdef DMEM_WR_ACK_EN
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              data_out_q   <= 32'h0;
              resp_err_q   <= ~in_range;
              req_ready_q  <= 1'b0;
`endif
            end else if (rd) begin
              if (wr) err_sticky_q <= 1'b1;
              // Snapshot now so later writes cannot alter the pending response.
              data_out_q  <= (in_range && !wr) ? mem[index] : 32'h0;
              resp_err_q  <= wr | ~in_range;
              req_ready_q <= 1'b0;
              if (RD_LATENCY == 1) begin
                state_q      <= RESP;
                resp_valid_q <= 1'b1;
              end else begin
                cnt_q   <= 2'(RD_LATENCY - 2);
                state_q <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign data_out   = data_out_q;
  assign resp_err   = resp_err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
// Honors DMEM_WR_ACK_EN when defined.
module tb_dmem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, gwe, rd, bw0, bw1, bw2, bw3;
  logic [31:0] addr, data_in, data_out;
  logic        resp_valid, resp_ready, resp_err, err_sticky;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_mem [int];
  bit model_sticky = 1'b0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .RD_LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .gwe(gwe), .rd(rd), .bw0(bw0), .bw1(bw1), .bw2(bw2), .bw3(bw3),
    .addr(addr), .data_in(data_in), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .data_out(data_out), .resp_err(resp_err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic bit f_in_range(input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off / 4 < longint'(DEPTH));
  endfunction

  function automatic int f_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [31:0] f_exp_data(input logic [31:0] a, input bit g);
    if (g || !f_in_range(a)) return 32'h0;
    return model_mem.exists(f_idx(a)) ? model_mem[f_idx(a)] : 32'hxxxx_xxxx;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input bit g, input logic [3:0] bw);
    logic [31:0] w;
    if (!(g || bw != 4'b0)) return;
    if (!f_in_range(a)) begin model_sticky = 1'b1; return; end
    w = model_mem.exists(f_idx(a)) ? model_mem[f_idx(a)] : 32'hxxxx_xxxx;
    for (int i = 0; i < 4; i++) if (g || bw[i]) w[8*i +: 8] = d[8*i +: 8];
    model_mem[f_idx(a)] = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; gwe = 1'b0; rd = 1'b0;
    {bw3, bw2, bw1, bw0} = 4'b0;
    resp_ready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit g, input logic [3:0] bw);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin step(); n++; end
    if (req_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL write_ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1; rd = 1'b0; gwe = g; {bw3, bw2, bw1, bw0} = bw; addr = a; data_in = d;
    step();
    req_valid = 1'b0; gwe = 1'b0; {bw3, bw2, bw1, bw0} = 4'b0;
    model_write(a, d, g, bw);
`ifdef DMEM_WR_ACK_EN
    if (g || bw != 4'b0) begin
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin step(); n++; end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
    end
`endif
  endtask

  task automatic do_read(input logic [31:0] a, input bit g, input int hold,
                         output int lat, output logic [31:0] dat, output logic err);
    req_valid = 1'b1; rd = 1'b1; gwe = g; addr = a; data_in = $urandom;
    step();
    req_valid = 1'b0; rd = 1'b0; gwe = 1'b0;
    if (g) model_sticky = 1'b1;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    dat = data_out;
    err = resp_err;
    repeat (hold) step();
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    addr = 32'h0; data_in = 32'h0;
    rst = 1'b1;
    step(); step();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err_sticky: got %b expected 0", err_sticky); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
`ifdef DMEM_WR_ACK_EN
    for (int k = 0; k < 64; k++) do_write(BASE + 32'(k * 4), $urandom, 1'b1, 4'b0);
    do_write(BASE + 32'((DEPTH - 1) * 4), $urandom, 1'b1, 4'b0);
`else
    int busy;
    logic [31:0] a, d;
    busy = 0;
    for (int k = 0; k <= 64; k++) begin
      a = (k == 64) ? BASE + 32'((DEPTH - 1) * 4) : BASE + 32'(k * 4);
      d = $urandom;
      req_valid = 1'b1; gwe = 1'b1; rd = 1'b0; addr = a; data_in = d;
      step();
      model_write(a, d, 1'b1, 4'b0);
      if (req_ready !== 1'b1) busy++;
    end
    idle_inputs();
    checks++; if (busy != 0) begin errors++; $display("FAIL back_to_back_ready: got %0d busy cycles expected 0", busy); end
`endif
  endtask

  task automatic test_basic();
    int lat; logic [31:0] d; logic e;
    do_write(BASE + 32'h10, 32'hDEADBEEF, 1'b1, 4'b0000);
    do_read(BASE + 32'h10, 1'b0, 0, lat, d, e);
    checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_data: got %h expected deadbeef", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", e); end
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL basic_after_hs: got ready=%b valid=%b expected 1 0", req_ready, resp_valid); end
    do_write(BASE + 32'h12, 32'h00AB0000, 1'b0, 4'b0100);
    do_read(BASE + 32'h10, 1'b0, 0, lat, d, e);
    checks++; if (d !== 32'hDEABBEEF) begin errors++; $display("FAIL lane2_merge: got %h expected deabbeef", d); end
  endtask

  task automatic test_raw();
    int lat; logic [31:0] d, w; logic e;
    w = $urandom;
    do_write(BASE + 32'h14, w, 1'b1, 4'b0);
    do_read(BASE + 32'h14, 1'b0, 0, lat, d, e);
    checks++; if (d !== w) begin errors++; $display("FAIL read_after_write: got %h expected %h", d, w); end
  endtask

  task automatic test_backpressure();
    int n, bad; int lat; logic [31:0] d; logic e;
    req_valid = 1'b1; rd = 1'b1; addr = BASE + 32'h10;
    step();
    req_valid = 1'b0; rd = 1'b0;
    n = 1;
    while (resp_valid !== 1'b1 && n < 20) begin step(); n++; end
    checks++; if (n != LAT) begin errors++; $display("FAIL bp_latency: got %0d expected %0d", n, LAT); end
    // A write presented while busy must be ignored.
    req_valid = 1'b1; gwe = 1'b1; data_in = 32'h5A5A5A5A;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (resp_valid !== 1'b1 || data_out !== 32'hDEABBEEF || req_ready !== 1'b0) bad++;
      step();
    end
    req_valid = 1'b0; gwe = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", bad); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got ready=%b valid=%b expected 1 0", req_ready, resp_valid); end
    do_read(BASE + 32'h10, 1'b0, 0, lat, d, e);
    checks++; if (d !== 32'hDEABBEEF) begin errors++; $display("FAIL bp_ignored_write: got %h expected deabbeef", d); end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] d; logic e;
    do_write(BASE + 32'h20, 32'h11223344, 1'b1, 4'b0);
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL illegal_sticky_pre: got %b expected 0", err_sticky); end
    do_read(BASE + 32'h20, 1'b1, 0, lat, d, e);
    checks++; if (lat != LAT) begin errors++; $display("FAIL illegal_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (d !== 32'h0 || e !== 1'b1) begin errors++; $display("FAIL illegal_resp: got data=%h err=%b expected 0 1", d, e); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b expected 1", err_sticky); end
    do_read(BASE + 32'h20, 1'b0, 0, lat, d, e);
    checks++; if (d !== 32'h11223344 || e !== 1'b0) begin errors++; $display("FAIL illegal_no_write: got data=%h err=%b expected 11223344 0", d, e); end
  endtask

  task automatic test_reset_mid();
    int seen; int lat; logic [31:0] d; logic e;
    req_valid = 1'b1; rd = 1'b1; addr = BASE + 32'h10;
    step();
    req_valid = 1'b0; rd = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_sticky = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || err_sticky !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got valid=%b ready=%b sticky=%b expected 0 1 0", resp_valid, req_ready, err_sticky);
    end
    seen = 0;
    repeat (6) begin step(); if (resp_valid !== 1'b0) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL reset_mid_no_resp: got %0d valid cycles expected 0", seen); end
    do_read(BASE + 32'h10, 1'b0, 0, lat, d, e);
    checks++; if (d !== 32'hDEABBEEF) begin errors++; $display("FAIL reset_mem_kept: got %h expected deabbeef", d); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] d, a; logic e;
    a = BASE + 32'(DEPTH * 4);
    do_read(a, 1'b0, 0, lat, d, e);
    checks++; if (lat != LAT || d !== 32'h0 || e !== 1'b1) begin
      errors++; $display("FAIL oor_read: got lat=%0d data=%h err=%b expected %0d 0 1", lat, d, e, LAT);
    end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL oor_read_sticky: got %b expected 0", err_sticky); end
    do_write(a, 32'hCAFEF00D, 1'b1, 4'b0);
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL oor_write_sticky: got %b expected 1", err_sticky); end
    do_read(BASE, 1'b0, 0, lat, d, e);
    checks++; if (d !== f_exp_data(BASE, 1'b0)) begin errors++; $display("FAIL oor_no_alias: got %h expected %h", d, f_exp_data(BASE, 1'b0)); end
    a = BASE + 32'((DEPTH - 1) * 4) + 32'd3;
    do_read(a, 1'b0, 0, lat, d, e);
    checks++; if (d !== f_exp_data(a, 1'b0) || e !== 1'b0) begin errors++; $display("FAIL last_word: got %h err=%b expected %h 0", d, e, f_exp_data(a, 1'b0)); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] d, a, ed; logic e; bit ee, g;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 7) == 0) a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
      else a = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      end else begin
        g = ($urandom_range(0, 9) == 0);
        ed = f_exp_data(a, g);
        ee = g || !f_in_range(a);
        do_read(a, g, $urandom_range(0, 3), lat, d, e);
        checks++; if (lat != LAT || d !== ed || e !== ee) begin
          errors++; $display("FAIL random_read @%h: got lat=%0d data=%h err=%b expected %0d %h %b", a, lat, d, e, LAT, ed, ee);
        end
      end
    end
    checks++; if (err_sticky !== model_sticky) begin errors++; $display("FAIL random_sticky: got %b expected %b", err_sticky, model_sticky); end
  endtask

`ifdef DMEM_WR_ACK_EN
  task automatic test_wr_ack();
    int bad;
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      addr = (k == 0) ? BASE + 32'h30 : BASE + 32'(DEPTH * 4);
      req_valid = 1'b1; gwe = 1'b1; data_in = 32'h12345678;
      step();
      req_valid = 1'b0; gwe = 1'b0;
      model_write(addr, 32'h12345678, 1'b1, 4'b0);
      checks++; if (resp_valid !== 1'b1 || data_out !== 32'h0 || resp_err !== (k == 1) || req_ready !== 1'b0) begin
        errors++; $display("FAIL wr_ack %0d: got valid=%b data=%h err=%b ready=%b", k, resp_valid, data_out, resp_err, req_ready);
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      if (req_ready !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wr_ack_release: got %0d expected 0", bad); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_raw();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_out_of_range();
    test_random();
`ifdef DMEM_WR_ACK_EN
    test_wr_ack();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
